axis_bram_master: RTL

//  Downstream drain stage of the FFT core. On go, reads FFT_SIZE complex results from the
//  FFT working BRAM in natural order (0..FFT_SIZE-1) and emits them as an AXI-stream packet,

---
 rtl/axis_bram_master_pkg.sv | 17 +
 rtl/axis_skid_fifo.sv | 45 ++++
 rtl/axis_bram_master.sv | 139 +++++++++++++
 3 files changed

// File: rtl/axis_bram_master_pkg.sv
// Shared widths and the FIFO entry layout for the FFT output drain stage.
package axis_bram_master_pkg;

  localparam int ADDR_WIDTH     = 12;
  localparam int DATA_WIDTH     = 32;
  localparam int OUT_AXI_WIDTH  = 32;
  localparam int OUT_BYTE_COUNT = OUT_AXI_WIDTH / 8;

  // One queued stream beat: BRAM word plus its end-of-frame tag.
  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;

  localparam int BEAT_W = $bits(beat_t);

endpackage

// File: rtl/axis_skid_fifo.sv
// Small register FIFO. Entry 0 is always the head, so the output is a flop
// rather than a read mux; a pop shifts every entry down by one.
module axis_skid_fifo #(
  parameter  int WIDTH = 33,
  parameter  int DEPTH = 2,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [OCC_W-1:0] occ
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [DEPTH-1:0][WIDTH-1:0] shifted;
  logic [OCC_W-1:0]            wr_idx;

  // After a same-cycle pop the free slot moves down by one.
  assign wr_idx  = occ - OCC_W'(pop);
  assign shifted = {{WIDTH{1'b0}}, mem[DEPTH-1:1]};
  assign head    = mem[0];

  // Storage: write lands at the first free slot, otherwise shift on pop.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push && wr_idx == OCC_W'(i)) mem[i] <= din;
      else if (pop)                    mem[i] <= shifted[i];
    end
  end

  // Occupancy; push and pop together leave it unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ <= '0;
    end else begin
      occ <= occ + OCC_W'(push) - OCC_W'(pop);
      assert (!(push && !pop && occ == OCC_W'(DEPTH)));
      assert (!(pop && occ == '0));
    end
  end

endmodule

// File: rtl/axis_bram_master.sv
// Drains one FFT frame from the working BRAM in natural order and streams it
// out as a single AXI-stream packet. Reads are issued only while the output
// FIFO has room for them (queued + in-flight), so backpressure never drops data.
module axis_bram_master
  import axis_bram_master_pkg::*;
#(
  parameter int FFT_SIZE   = 4096,
  parameter int RD_LATENCY = 1,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      axis_bram_master_go,
  output logic                      axis_bram_master_busy,
  output logic [ADDR_WIDTH-1:0]     axis_mem2m_raddr,
  output logic                      axis_mem2m_re,
  input  logic [DATA_WIDTH-1:0]     axis_mem2m_rdata,
  output logic                      axis_fft2mag_tvalid,
  input  logic                      axis_fft2mag_tready,
  output logic                      axis_fft2mag_tlast,
  output logic [OUT_AXI_WIDTH-1:0]  axis_fft2mag_tdata,
  output logic [OUT_BYTE_COUNT-1:0] axis_fft2mag_tkeep
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam int CR_W  = OCC_W + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FFT_SIZE - 1);

  if (OUT_AXI_WIDTH != DATA_WIDTH) begin : g_chk_width
    $error("stream width must equal BRAM data width");
  end
  if (FFT_SIZE != (1 << ADDR_WIDTH)) begin : g_chk_size
    $error("FFT_SIZE must equal 2**ADDR_WIDTH");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > 2) begin : g_chk_lat
    $error("RD_LATENCY must be 1 or 2");
  end
  if (FIFO_DEPTH < RD_LATENCY + 1) begin : g_chk_depth
    $error("FIFO_DEPTH must cover RD_LATENCY+1 beats");
  end

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] rd_cnt;
  logic [ADDR_WIDTH-1:0] beat_cnt;
  logic [RD_LATENCY:0]   vld_pipe;
  logic [RD_LATENCY:0]   lst_pipe;
  logic [RD_LATENCY-1:0] vld_q;
  logic [RD_LATENCY-1:0] lst_q;
  logic [CR_W-1:0]       inflight;
  logic [CR_W-1:0]       credit_used;
  logic [OCC_W-1:0]      occ;
  logic                  pop;
  logic                  push;
  beat_t                 push_beat;
  beat_t                 head_beat;

  assign pop  = axis_fft2mag_tvalid & axis_fft2mag_tready;
  assign push = vld_pipe[RD_LATENCY];

  // Slots already claimed: queued beats plus reads still in the BRAM pipe,
  // less the beat leaving this cycle.
  assign credit_used   = CR_W'(occ) + inflight - CR_W'(pop);
  assign axis_mem2m_re = (state == ST_ISSUE) && (credit_used < CR_W'(FIFO_DEPTH));
  assign axis_mem2m_raddr = rd_cnt;

  // Stage 0 is the read being issued now; stage RD_LATENCY is its data arriving.
  assign vld_pipe = {vld_q, axis_mem2m_re};
  assign lst_pipe = {lst_q, (rd_cnt == LAST_ADDR)};

  assign push_beat = '{last: lst_pipe[RD_LATENCY], data: axis_mem2m_rdata};

  assign axis_bram_master_busy = (state != ST_IDLE);
  assign axis_fft2mag_tvalid   = (occ != '0);
  assign axis_fft2mag_tlast    = axis_fft2mag_tvalid & head_beat.last;
  assign axis_fft2mag_tdata    = head_beat.data;
  assign axis_fft2mag_tkeep    = '1;

  // Track outstanding reads and carry the last-address tag alongside them.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q    <= '0;
      lst_q    <= '0;
      inflight <= '0;
    end else begin
      vld_q    <= vld_pipe[RD_LATENCY-1:0];
      lst_q    <= lst_pipe[RD_LATENCY-1:0];
      inflight <= inflight + CR_W'(axis_mem2m_re) - CR_W'(push);
    end
  end

  // Frame sequencing and the natural-order read address.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      rd_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE:  if (axis_bram_master_go) state <= ST_ISSUE;
        ST_ISSUE: if (axis_mem2m_re) begin
                    if (rd_cnt == LAST_ADDR) state  <= ST_DRAIN;
                    else                     rd_cnt <= rd_cnt + 1'b1;
                  end
        ST_DRAIN: if (pop && head_beat.last) begin
                    state  <= ST_IDLE;
                    rd_cnt <= '0;
                  end
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Accepted-beat count; the tag on the head must agree with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt <= '0;
    end else begin
      if (pop) beat_cnt <= head_beat.last ? '0 : beat_cnt + 1'b1;
      if (axis_fft2mag_tvalid) assert (head_beat.last == (beat_cnt == LAST_ADDR));
    end
  end

  axis_skid_fifo #(
    .WIDTH (BEAT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (push_beat),
    .pop   (pop),
    .head  (head_beat),
    .occ   (occ)
  );

endmodule
